// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM byte-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam logic RW_WRITE  = 1'b1;
  localparam logic RW_READ   = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [1:0]  LAST_LANE      = 2'(BYTES_PER_WORD - 1);

  // Big-endian lane select: lane 0 is the most significant byte.
  function automatic logic [7:0] lane_of(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_byte_sequencer.sv
// Byte counter, registered memory-port drive and read-assembly buffer.
// load starts a transfer (registers the first byte cycle); step is high
// during each byte cycle and either advances to the next byte or closes
// the port after the last one.
module mem_byte_sequencer
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              ld_rw,
  input  logic              ld_size,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic [7:0]        m_rdata,
  output logic              last,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_wdata,
  output logic [31:0]       rbuf
);

  logic [1:0]  cnt;
  logic        rw_q;
  logic        size_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf_next;

  // Final byte of the transfer: lane 3 for words, the only lane for bytes.
  always_comb begin
    if (size_q == SIZE_WORD) last = (cnt == LAST_LANE);
    else                     last = (cnt == 2'd0);
  end

  // Merge the byte currently on the port into its lane of the buffer.
  always_comb begin
    rbuf_next = rbuf;
    if (size_q == SIZE_WORD) begin
      case (cnt)
        2'd0:    rbuf_next[31:24] = m_rdata;
        2'd1:    rbuf_next[23:16] = m_rdata;
        2'd2:    rbuf_next[15:8]  = m_rdata;
        default: rbuf_next[7:0]   = m_rdata;
      endcase
    end else begin
      rbuf_next = {24'b0, m_rdata};
    end
  end

  // Port outputs are loaded one cycle ahead so they are stable for the
  // whole byte cycle they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      rw_q    <= RW_READ;
      size_q  <= SIZE_BYTE;
      wdata_q <= '0;
      rbuf    <= '0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (load) begin
      cnt     <= '0;
      rw_q    <= ld_rw;
      size_q  <= ld_size;
      wdata_q <= ld_wdata;
      rbuf    <= '0;
      m_en    <= 1'b1;
      m_we    <= (ld_rw == RW_WRITE);
      if (ld_size == SIZE_WORD) begin
        m_addr  <= {ld_addr[ADDR_W-1:2], 2'b00};
        m_wdata <= lane_of(ld_wdata, 2'd0);
      end else begin
        m_addr  <= ld_addr;
        m_wdata <= ld_wdata[7:0];
      end
    end else if (step) begin
      if (rw_q == RW_READ) rbuf <= rbuf_next;
      if (!last) begin
        cnt     <= cnt + 2'd1;
        m_addr  <= m_addr + 1'b1;
        m_wdata <= lane_of(wdata_q, cnt + 2'd1);
      end else begin
        cnt     <= '0;
        m_en    <= 1'b0;
        m_we    <= 1'b0;
        m_addr  <= '0;
        m_wdata <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-wide data RAM port between instruction fetch and the MEM
// stage, serialising word accesses into four big-endian byte cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IF_req,
  input  logic [ADDR_W-1:0] IF_addr,
  output logic              IF_ack,
  output logic [31:0]       IF_data,
  output logic              IF_stall,
  input  logic              MEM_req,
  input  logic              MEM_RW,
  input  logic              MEM_size,
  input  logic [ADDR_W-1:0] MEM_addr,
  input  logic [31:0]       MEM_wdata,
  output logic              MEM_ack,
  output logic [31:0]       MEM_rdata,
  output logic              MEM_stall,
  output logic              M_en,
  output logic              M_we,
  output logic [ADDR_W-1:0] M_addr,
  output logic [7:0]        M_wdata,
  input  logic [7:0]        M_rdata
);

  state_t            state, state_next;
  owner_t            owner_q, prev_grant;
  owner_t            grant_owner;
  logic              grant;
  logic              seq_last;
  logic [31:0]       rbuf;
  logic              ld_rw;
  logic              ld_size;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;

  // Arbitration in IDLE: MEM wins a tie unless it had the previous grant.
  always_comb begin
    grant       = 1'b0;
    grant_owner = OWN_IF;
    if (state == IDLE) begin
      if (MEM_req && (!IF_req || prev_grant != OWN_MEM)) begin
        grant       = 1'b1;
        grant_owner = OWN_MEM;
      end else if (IF_req) begin
        grant       = 1'b1;
        grant_owner = OWN_IF;
      end
    end
  end

  // Request fields for the sequencer; fetches are always word reads.
  always_comb begin
    if (grant_owner == OWN_MEM) begin
      ld_rw    = MEM_RW;
      ld_size  = MEM_size;
      ld_addr  = MEM_addr;
      ld_wdata = MEM_wdata;
    end else begin
      ld_rw    = RW_READ;
      ld_size  = SIZE_WORD;
      ld_addr  = IF_addr;
      ld_wdata = '0;
    end
  end

  // State register plus owner and previous-grant bookkeeping.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      owner_q    <= OWN_IF;
      prev_grant <= OWN_IF;
    end else begin
      state <= state_next;
      if (grant)          owner_q    <= grant_owner;
      if (state == DONE)  prev_grant <= owner_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = XFER;
      XFER:    if (seq_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs: ack and data only for the owner during DONE.
  always_comb begin
    IF_ack    = (state == DONE) && (owner_q == OWN_IF);
    MEM_ack   = (state == DONE) && (owner_q == OWN_MEM);
    IF_data   = IF_ack  ? rbuf : '0;
    MEM_rdata = MEM_ack ? rbuf : '0;
    IF_stall  = IF_req  & ~IF_ack;
    MEM_stall = MEM_req & ~MEM_ack;
  end

  mem_byte_sequencer #(
    .ADDR_W (ADDR_W)
  ) u_seq (
    .clk      (Clk),
    .rst      (Reset),
    .load     (grant),
    .step     (state == XFER),
    .ld_rw    (ld_rw),
    .ld_size  (ld_size),
    .ld_addr  (ld_addr),
    .ld_wdata (ld_wdata),
    .m_rdata  (M_rdata),
    .last     (seq_last),
    .m_en     (M_en),
    .m_we     (M_we),
    .m_addr   (M_addr),
    .m_wdata  (M_wdata),
    .rbuf     (rbuf)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural byte RAM.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        IF_req = 1'b0;
  logic [7:0]  IF_addr = '0;
  logic        IF_ack;
  logic [31:0] IF_data;
  logic        IF_stall;
  logic        MEM_req = 1'b0;
  logic        MEM_RW = 1'b0;
  logic        MEM_size = 1'b0;
  logic [7:0]  MEM_addr = '0;
  logic [31:0] MEM_wdata = '0;
  logic        MEM_ack;
  logic [31:0] MEM_rdata;
  logic        MEM_stall;
  logic        M_en;
  logic        M_we;
  logic [7:0]  M_addr;
  logic [7:0]  M_wdata;
  logic [7:0]  M_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  mem_port_arbiter #(.ADDR_W(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .IF_req(IF_req), .IF_addr(IF_addr), .IF_ack(IF_ack), .IF_data(IF_data), .IF_stall(IF_stall),
    .MEM_req(MEM_req), .MEM_RW(MEM_RW), .MEM_size(MEM_size), .MEM_addr(MEM_addr),
    .MEM_wdata(MEM_wdata), .MEM_ack(MEM_ack), .MEM_rdata(MEM_rdata), .MEM_stall(MEM_stall),
    .M_en(M_en), .M_we(M_we), .M_addr(M_addr), .M_wdata(M_wdata), .M_rdata(M_rdata)
  );

  // Byte RAM model: initial pattern, then writes on enabled write cycles.
  function automatic logic [7:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i < 8) return 8'(8'h11 * (i + 1));
    return b ^ 8'h5A;
  endfunction

  logic [7:0] mem [256];
  logic       mem_init = 1'b1;

  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (M_en && M_we) begin
      mem[M_addr] <= M_wdata;
    end
  end

  assign M_rdata = mem[M_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_mem;
    bit          rw;
    bit          word;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          chg_at;
  } vec_t;

  typedef struct {
    bit          is_mem;
    bit          chk_data;
    logic [31:0] data;
  } sb_t;

  sb_t sb[$];

  function automatic vec_t mk(bit m, bit rw, bit wd, logic [7:0] a, logic [31:0] wdat,
                              logic [31:0] e, int c);
    vec_t v;
    v.is_mem = m; v.rw = rw; v.word = wd; v.addr = a; v.wdata = wdat; v.exp = e; v.chg_at = c;
    return v;
  endfunction

  // Pop the scoreboard at an ack and compare owner and read data.
  task automatic check_ack(input string name);
    sb_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({name, "_owner"}, {30'b0, IF_ack, MEM_ack}, {30'b0, !e.is_mem, e.is_mem});
    if (e.chk_data) chk({name, "_data"}, e.is_mem ? MEM_rdata : IF_data, e.data);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int         lat;
    int         nb;
    bit         got;
    logic [7:0] base;
    logic [31:0] lane;
    nb   = v.word ? 4 : 1;
    base = v.word ? {v.addr[7:2], 2'b00} : v.addr;
    @(posedge Clk); #1;
    if (v.is_mem) begin
      MEM_req = 1'b1; MEM_RW = v.rw; MEM_size = v.word; MEM_addr = v.addr; MEM_wdata = v.wdata;
    end else begin
      IF_req = 1'b1; IF_addr = v.addr;
    end
    sb.push_back('{v.is_mem, !v.rw, v.exp});
    lat = 0;
    got = 0;
    while (!got && lat <= 20) begin
      @(negedge Clk);
      if (lat >= 1 && lat <= nb) begin
        chk({name, "_m_en"}, {31'b0, M_en}, 32'd1);
        chk({name, "_m_addr"}, {24'b0, M_addr}, {24'b0, 8'(base + 8'(lat - 1))});
        chk({name, "_m_we"}, {31'b0, M_we}, {31'b0, v.rw});
        if (v.rw) begin
          lane = v.word ? ((v.wdata >> (8 * (4 - lat))) & 32'hFF) : {24'b0, v.wdata[7:0]};
          chk({name, "_m_wdata"}, {24'b0, M_wdata}, lane);
        end
      end else begin
        chk({name, "_m_en_idle"}, {31'b0, M_en}, 32'd0);
      end
      if (IF_ack || MEM_ack) begin
        got = 1;
        chk({name, "_latency"}, 32'(lat), 32'(nb + 1));
        check_ack(name);
      end
      chk({name, "_stall"}, {31'b0, v.is_mem ? MEM_stall : IF_stall}, {31'b0, !got});
      if (lat == v.chg_at) begin
        MEM_addr  = v.addr ^ 8'h30;
        MEM_wdata = ~v.wdata;
      end
      if (!got) lat++;
    end
    if (!got) chk({name, "_timeout"}, 32'd1, 32'd0);
    @(posedge Clk); #1;
    IF_req = 1'b0; MEM_req = 1'b0;
  endtask

  vec_t vecs [10];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    bit exp_mack, exp_iack;

    vecs[0] = mk(0, 0, 1, 8'h06, 32'h0,        32'h55667788, -1);
    vecs[1] = mk(1, 1, 1, 8'hBC, 32'hDEADBEEF, 32'h0,        -1);
    vecs[2] = mk(1, 0, 1, 8'hBC, 32'h0,        32'hDEADBEEF, -1);
    vecs[3] = mk(1, 1, 0, 8'hC1, 32'h123456A5, 32'h0,        -1);
    vecs[4] = mk(1, 0, 0, 8'hC1, 32'h0,        32'h000000A5, -1);
    vecs[5] = mk(0, 0, 1, 8'h01, 32'h0,        32'h11223344, -1);
    vecs[6] = mk(1, 0, 0, 8'h05, 32'h0,        32'h00000066, -1);
    vecs[7] = mk(1, 1, 1, 8'h10, 32'h01020304, 32'h0,         2);
    vecs[8] = mk(1, 0, 1, 8'h10, 32'h0,        32'h01020304, -1);
    vecs[9] = mk(1, 0, 1, 8'h22, 32'h0,        32'h7A7B7879, -1);

    // Reset state.
    repeat (3) @(negedge Clk);
    chk("rst_acks",  {30'b0, IF_ack, MEM_ack}, 32'd0);
    chk("rst_data",  IF_data | MEM_rdata, 32'd0);
    chk("rst_mport", {M_en, M_we, 6'b0, M_addr, M_wdata, 8'b0}, 32'd0);
    Reset = 1'b0;
    mem_init = 1'b0;

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    chk("mem_BC", {mem[8'hBC], mem[8'hBD], mem[8'hBE], mem[8'hBF]}, 32'hDEADBEEF);
    chk("mem_C0", {24'b0, mem[8'hC0]}, 32'h9A);
    chk("mem_C1", {24'b0, mem[8'hC1]}, 32'hA5);
    chk("mem_C2", {24'b0, mem[8'hC2]}, 32'h98);
    chk("mem_20", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'h7A7B7879);

    // Reset during the third byte of a word store to C4.
    @(posedge Clk); #1;
    MEM_req = 1'b1; MEM_RW = 1'b1; MEM_size = 1'b1; MEM_addr = 8'hC4; MEM_wdata = 32'hCAFEF00D;
    repeat (4) @(negedge Clk);
    chk("rst_mid_addr", {24'b0, M_addr}, 32'hC6);
    Reset = 1'b1;
    MEM_req = 1'b0;
    #1;
    chk("rst_mid_acks",  {30'b0, IF_ack, MEM_ack}, 32'd0);
    chk("rst_mid_data",  IF_data | MEM_rdata, 32'd0);
    chk("rst_mid_mport", {M_en, M_we, 6'b0, M_addr, M_wdata, 8'b0}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      chk("rst_no_ack", {30'b0, IF_ack, MEM_ack}, 32'd0);
    end
    chk("rst_mem_C4", {mem[8'hC4], mem[8'hC5], mem[8'hC6], mem[8'hC7]},
        {8'hCA, 8'hFE, pat(8'hC6), pat(8'hC7)});

    // Both requesters held: MEM, IF, MEM, IF (previous grant cleared to IF).
    sb.push_back('{1'b1, 1'b1, 32'h11223344});
    sb.push_back('{1'b0, 1'b1, 32'h55667788});
    sb.push_back('{1'b1, 1'b1, 32'h11223344});
    sb.push_back('{1'b0, 1'b1, 32'h55667788});
    @(posedge Clk); #1;
    MEM_req = 1'b1; MEM_RW = 1'b0; MEM_size = 1'b1; MEM_addr = 8'h00;
    IF_req  = 1'b1; IF_addr = 8'h04;
    for (int lat = 0; lat < 24; lat++) begin
      @(negedge Clk);
      exp_mack = (lat == 5) || (lat == 17);
      exp_iack = (lat == 11) || (lat == 23);
      chk("both_acks",  {30'b0, IF_ack, MEM_ack}, {30'b0, exp_iack, exp_mack});
      chk("both_istall", {31'b0, IF_stall},  {31'b0, !exp_iack});
      chk("both_mstall", {31'b0, MEM_stall}, {31'b0, !exp_mack});
      if (IF_ack || MEM_ack) check_ack("both");
    end
    @(posedge Clk); #1;
    IF_req = 1'b0; MEM_req = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    run_vec("post_fetch", vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares the single byte-wide data RAM port between the instruction-fetch stage (word reads) and the MEM stage (byte/word loads and stores). Each 32-bit word access is serialized into four one-byte memory cycles in big-endian order. The block produces stall signals that the hazard unit folds into PC_LE and IF_ID_enable. It sits between the pipeline stages (IF, EX_MEM/MEM_WB) and the RAM byte array.

## Interface
- ADDR_W, 8, byte address width of the memory port
- Clk  in  1  pipeline clock, rising edge
- Reset  in  1  asynchronous, active-high
- IF_req  in  1  fetch request; held high until IF_ack
- IF_addr  in  ADDR_W  fetch byte address; low 2 bits ignored
- IF_ack  out  1  one-cycle pulse; IF_data valid in the same cycle
- IF_data  out  32  fetched word
- IF_stall  out  1  IF_req & ~IF_ack
- MEM_req  in  1  data request; held high until MEM_ack
- MEM_RW  in  1  1 = write, 0 = read
- MEM_size  in  1  1 = word, 0 = byte
- MEM_addr  in  ADDR_W  data byte address
- MEM_wdata  in  32  store data; a byte store uses [7:0]
- MEM_ack  out  1  one-cycle pulse; MEM_rdata valid in the same cycle
- MEM_rdata  out  32  load data; a byte load is zero-extended
- MEM_stall  out  1  MEM_req & ~MEM_ack
- M_en  out  1  memory byte-cycle enable
- M_we  out  1  memory write strobe for the current byte
- M_addr  out  ADDR_W  memory byte address
- M_wdata  out  8  memory write byte
- M_rdata  in  8  memory read byte, combinational with M_addr

## Operation
- **FSM states:** IDLE, XFER, DONE.
- **IDLE:**
  - Sample the requests. If exactly one is high, grant it.
  - If both are high: grant MEM, unless the previous grant was MEM, in which case grant IF (two-way alternation, no starvation).
  - On a grant, latch the owner, RW, size and address, then go to XFER with byte counter cnt = 0.
- **XFER:**
  - M_en = 1 on every cycle.
  - Word access: M_addr = {addr[7:2],2'b00} + cnt.
    - Byte cnt maps to data bits [31-8·cnt -: 8] (big-endian, byte 0 = MSB).
    - Aligned base address, so no wrap occurs.
  - Byte access: M_addr = addr, one cycle only.
  - Read: capture M_rdata into the lane buffer at the end of each cycle.
  - Write: M_we = 1 and M_wdata = the selected lane of the latched wdata.
  - Advance cnt each cycle. Leave XFER after cnt = 3 (word) or cnt = 0 (byte).
  - IF grants are always word reads. IF_addr low bits are discarded.
- **DONE:**
  - Pulse the owner's ack for one cycle, with read data driven from the buffer.
  - Record the owner as the previous grant, then return to IDLE.
- **Requester protocol:**
  - Request fields are latched at grant, so changes after grant are ignored.
  - The requester deasserts req on the clock edge after seeing ack.
  - A req still high in IDLE afterwards is a new request.
- **Reset:**
  - Mid-transfer reset returns the block to IDLE immediately.
  - Bytes already written stay written (no rollback). No ack is issued.
  - The previous-grant flag clears to IF.
- A write and read to the same address from different owners are strictly ordered by grant order.

## Timing
- Reset values: IF_ack = MEM_ack = 0, IF_data = MEM_rdata = 0, M_en = M_we = 0, M_addr = 0, M_wdata = 0, state = IDLE, cnt = 0.
- Requests sampled in IDLE at cycle N:
  - Word transfer: byte cycles N+1..N+4, ack at N+5 (5-cycle latency).
  - Byte transfer: byte cycle N+1, ack at N+2.
- Back-to-back throughput: one word per 6 cycles (IDLE + 4 XFER + DONE).
- M_* outputs are registered from state and cnt. They are valid for the whole XFER cycle, and M_en = 0 outside XFER.
- Stall outputs are combinational, so the pipeline holds in the same cycle the request rises.
- A request that arrives during XFER/DONE waits. It is considered at the next IDLE.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, XFER, DONE);
  - owner encodings (OWN_IF, OWN_MEM);
  - RW_WRITE = 1 and SIZE_WORD = 1;
  - BYTES_PER_WORD = 4.
- Sub-module mem_byte_sequencer holds the counter, the lane select and the read-assembly buffer. It is instantiated once. The top level holds the arbitration, the FSM and the handshake.

## Test plan
- IF-only fetch: IF_addr = 8'h06, memory 00..07 = 11..88 -> M_addr 04,05,06,07 on cycles N+1..N+4; IF_ack at N+5 with IF_data = 32'h55667788.
- MEM word store: addr 8'hBC, wdata 32'hDEADBEEF -> mem[BC..BF] = DE,AD,BE,EF; MEM_ack at N+5. A following word load from 8'hBC returns 32'hDEADBEEF.
- MEM byte store/load: store 32'h000000A5 to 8'hC1 -> only mem[C1] changes. A byte load from C1 returns 32'h000000A5 with ack at N+2.
- Simultaneous requests, both held continuously -> grant order MEM, IF, MEM, IF. IF_stall is high in all cycles except its ack cycles.
- Reset asserted at the 3rd byte of a word store to 8'hC4 -> mem[C4..C5] are written and mem[C6..C7] are unchanged. No ack is issued, and all outputs are 0 immediately.
- Request fields changed after grant (MEM_addr 8'h10 -> 8'h20 at N+2) -> the transfer completes at 8'h10..13.
